text_console_writer: RTL and testbench

//  Writer side of the 80x30 text VRAM. Takes a byte stream from the CPU/UART, places each char at a cursor and writes it into VRAM.

---
 rtl/text_console_writer.sv | 179 +++++++++++++++++
 tb/tb_text_console_writer.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/text_console_writer.sv
// Writer side of the 80x30 text VRAM.
// Accepts a byte stream, places each printable byte at the cursor, and
// handles CR/LF/BS/FF, line wrap and a hardware scroll through VRAM port A.
// VRAM word = row*WORDS_PER_ROW + col/4, byte lane = col%4 (little-endian).
module text_console_writer #(
  parameter int unsigned COLS          = 80,
  parameter int unsigned ROWS          = 30,
  parameter int unsigned WORDS_PER_ROW = COLS / 4,
  parameter logic [7:0]  BLANK         = 8'h20
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        char_valid,
  output logic        char_ready,
  input  logic [7:0]  char_data,
  output logic [10:0] vram_addr,
  output logic [31:0] vram_wdata,
  output logic [3:0]  vram_be,
  output logic        vram_we,
  input  logic [31:0] vram_rdata,
  output logic [4:0]  cursor_row,
  output logic [6:0]  cursor_col,
  output logic        busy
);

  localparam logic [10:0] ROW_WORDS   = 11'(WORDS_PER_ROW);
  localparam logic [10:0] TOTAL_WORDS = 11'(ROWS * WORDS_PER_ROW);
  localparam logic [10:0] LAST_WORD   = TOTAL_WORDS - 11'd1;
  // Last destination word of the row-copy phase; the bottom row is blanked after it.
  localparam logic [10:0] SCROLL_LAST = TOTAL_WORDS - ROW_WORDS - 11'd1;
  localparam logic [4:0]  LAST_ROW    = 5'(ROWS - 1);
  localparam logic [6:0]  LAST_COL    = 7'(COLS - 1);

  localparam logic [7:0] CH_BS = 8'h08;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_FF = 8'h0C;
  localparam logic [7:0] CH_CR = 8'h0D;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    SCROLL_RD,
    SCROLL_WR,
    FILL
  } state_t;

  state_t      state, state_n;
  logic [4:0]  row_n;
  logic [6:0]  col_n;
  logic [10:0] idx, idx_n;          // scroll / fill word index
  logic [7:0]  wr_byte, wr_byte_n;  // byte to store in WRITE
  logic        wr_adv, wr_adv_n;    // WRITE advances the cursor (not for BS)
  logic [10:0] cur_addr;

  assign cur_addr   = 11'(cursor_row) * ROW_WORDS + 11'(cursor_col >> 2);
  assign char_ready = (state == IDLE);
  assign busy       = (state != IDLE);

  // State and cursor registers; reset aborts any scroll/fill in progress.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state      <= IDLE;
      cursor_row <= '0;
      cursor_col <= '0;
      idx        <= '0;
      wr_byte    <= '0;
      wr_adv     <= 1'b0;
    end else begin
      state      <= state_n;
      cursor_row <= row_n;
      cursor_col <= col_n;
      idx        <= idx_n;
      wr_byte    <= wr_byte_n;
      wr_adv     <= wr_adv_n;
    end
  end

  // Next-state, cursor update and VRAM port A drive.
  always_comb begin
    state_n    = state;
    row_n      = cursor_row;
    col_n      = cursor_col;
    idx_n      = idx;
    wr_byte_n  = wr_byte;
    wr_adv_n   = wr_adv;
    vram_we    = 1'b0;
    vram_be    = '0;
    vram_addr  = '0;
    vram_wdata = '0;

    case (state)
      IDLE: begin
        if (char_valid) begin
          case (char_data)
            CH_CR: col_n = '0;
            CH_LF: begin
              if (cursor_row == LAST_ROW) begin
                idx_n   = '0;
                state_n = SCROLL_RD;
              end else begin
                row_n = cursor_row + 5'd1;
              end
            end
            CH_BS: begin
              if (cursor_col != '0) begin
                col_n     = cursor_col - 7'd1;
                wr_byte_n = BLANK;
                wr_adv_n  = 1'b0;
                state_n   = WRITE;
              end
            end
            CH_FF: begin
              row_n   = '0;
              col_n   = '0;
              idx_n   = '0;
              state_n = FILL;
            end
            default: begin
              wr_byte_n = char_data;
              wr_adv_n  = 1'b1;
              state_n   = WRITE;
            end
          endcase
        end
      end

      WRITE: begin
        vram_we    = 1'b1;
        vram_addr  = cur_addr;
        vram_be    = 4'b0001 << cursor_col[1:0];
        vram_wdata = {4{wr_byte}};
        state_n    = IDLE;
        if (wr_adv) begin
          if (cursor_col < LAST_COL) begin
            col_n = cursor_col + 7'd1;
          end else begin
            col_n = '0;
            if (cursor_row < LAST_ROW) begin
              row_n = cursor_row + 5'd1;
            end else begin
              idx_n   = '0;
              state_n = SCROLL_RD;
            end
          end
        end
      end

      // Present the source word one row below; its data returns next cycle.
      SCROLL_RD: begin
        vram_addr = idx + ROW_WORDS;
        state_n   = SCROLL_WR;
      end

      SCROLL_WR: begin
        vram_we    = 1'b1;
        vram_addr  = idx;
        vram_be    = '1;
        vram_wdata = vram_rdata;
        idx_n      = idx + 11'd1;
        state_n    = (idx == SCROLL_LAST) ? FILL : SCROLL_RD;
      end

      FILL: begin
        vram_we    = 1'b1;
        vram_addr  = idx;
        vram_be    = '1;
        vram_wdata = {4{BLANK}};
        if (idx == LAST_WORD) begin
          state_n = IDLE;
        end else begin
          idx_n = idx + 11'd1;
        end
      end

      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_text_console_writer.sv
// Self-checking bench for text_console_writer: vector table, directed
// scroll/fill/reset sequences, and random bytes against a screen model.
module tb_text_console_writer;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        char_valid = 1'b0;
  logic        char_ready;
  logic [7:0]  char_data = 8'h00;
  logic [10:0] vram_addr;
  logic [31:0] vram_wdata;
  logic [3:0]  vram_be;
  logic        vram_we;
  logic [31:0] vram_rdata = '0;
  logic [4:0]  cursor_row;
  logic [6:0]  cursor_col;
  logic        busy;

  text_console_writer #(
    .COLS (80),
    .ROWS (30),
    .BLANK(8'h20)
  ) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .char_valid(char_valid),
    .char_ready(char_ready),
    .char_data (char_data),
    .vram_addr (vram_addr),
    .vram_wdata(vram_wdata),
    .vram_be   (vram_be),
    .vram_we   (vram_we),
    .vram_rdata(vram_rdata),
    .cursor_row(cursor_row),
    .cursor_col(cursor_col),
    .busy      (busy)
  );

  always #5 Clk = ~Clk;

  // VRAM: byte-enable write, registered read (1-cycle latency).
  logic [31:0] mem [600];
  logic [31:0] wtmp;
  always @(posedge Clk) begin
    if (vram_we && vram_addr < 11'd600) begin
      wtmp = mem[vram_addr];
      for (int l = 0; l < 4; l++)
        if (vram_be[l]) wtmp[8*l +: 8] = vram_wdata[8*l +: 8];
      mem[vram_addr] <= wtmp;
    end
    vram_rdata <= (vram_addr < 11'd600) ? mem[vram_addr] : 32'h0;
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // ---------------- screen model ----------------
  logic [7:0] scr  [30][80];
  logic [7:0] snap [30][80];
  int mr = 0, mc = 0;
  int exp_busy;

  task automatic m_scroll();
    for (int r = 0; r < 29; r++)
      for (int c = 0; c < 80; c++) scr[r][c] = scr[r+1][c];
    for (int c = 0; c < 80; c++) scr[29][c] = 8'h20;
  endtask

  // Applies one byte to the model; returns the cycles the writer should be busy.
  task automatic m_put(input logic [7:0] b, output int cyc);
    cyc = 0;
    case (b)
      8'h0D: mc = 0;
      8'h0A: if (mr < 29) mr++; else begin m_scroll(); cyc = 1180; end
      8'h08: if (mc > 0) begin mc--; scr[mr][mc] = 8'h20; cyc = 1; end
      8'h0C: begin
        for (int r = 0; r < 30; r++)
          for (int c = 0; c < 80; c++) scr[r][c] = 8'h20;
        mr = 0; mc = 0; cyc = 600;
      end
      default: begin
        scr[mr][mc] = b;
        cyc = 1;
        if (mc < 79) mc++;
        else begin
          mc = 0;
          if (mr < 29) mr++; else begin m_scroll(); cyc += 1180; end
        end
      end
    endcase
  endtask

  function automatic logic [31:0] snap_word(input int w);
    int r, c0;
    r  = w / 20;
    c0 = (w % 20) * 4;
    return {snap[r][c0+3], snap[r][c0+2], snap[r][c0+1], snap[r][c0]};
  endfunction

  task automatic cmp_screen(input string name);
    int errs;
    logic [31:0] w;
    errs = 0;
    for (int r = 0; r < 30; r++)
      for (int c = 0; c < 80; c++) begin
        w = mem[r*20 + c/4];
        if (w[8*(c%4) +: 8] !== scr[r][c]) errs++;
      end
    chk(name, errs, 0);
  endtask

  // ---------------- driver ----------------
  typedef struct {
    logic        we;
    logic [10:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } cyc_t;
  cyc_t cyc_q[$];

  task automatic send(input logic [7:0] b);
    bit done;
    cyc_q.delete();
    done = 0;
    @(negedge Clk);
    char_valid = 1'b1;
    char_data  = b;
    @(posedge Clk);
    #1;
    char_valid = 1'b0;
    char_data  = 8'($urandom);
    for (int n = 0; n < 2000; n++) begin
      @(negedge Clk);
      if (char_ready) begin done = 1; break; end
      cyc_q.push_back('{vram_we, vram_addr, vram_be, vram_wdata});
    end
    if (!done) chk("busy_timeout", 0, 1);
    m_put(b, exp_busy);
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
    mr = 0; mc = 0;
  endtask

  function automatic int n_writes();
    int n = 0;
    foreach (cyc_q[i]) if (cyc_q[i].we) n++;
    return n;
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    bit          rst;
    logic [7:0]  ch;
    int          busy;
    int          nwr;
    logic [10:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
    int          row;
    int          col;
  } vec_t;
  vec_t tbl[$];

  initial begin
    int errs, k;
    bit got;
    logic [7:0] b;
    int rsel;

    tbl.push_back('{1'b1, 8'h41, 1, 1, 11'd0,  4'b0001, 32'h41414141, 0, 1});
    tbl.push_back('{1'b1, 8'h48, 1, 1, 11'd0,  4'b0001, 32'h48484848, 0, 1});
    tbl.push_back('{1'b0, 8'h45, 1, 1, 11'd0,  4'b0010, 32'h45454545, 0, 2});
    tbl.push_back('{1'b0, 8'h4C, 1, 1, 11'd0,  4'b0100, 32'h4C4C4C4C, 0, 3});
    tbl.push_back('{1'b0, 8'h4C, 1, 1, 11'd0,  4'b1000, 32'h4C4C4C4C, 0, 4});
    tbl.push_back('{1'b0, 8'h4F, 1, 1, 11'd1,  4'b0001, 32'h4F4F4F4F, 0, 5});
    tbl.push_back('{1'b0, 8'h08, 1, 1, 11'd1,  4'b0001, 32'h20202020, 0, 4});
    tbl.push_back('{1'b0, 8'h0D, 0, 0, 11'd0,  4'b0000, 32'h0,        0, 0});
    tbl.push_back('{1'b0, 8'h08, 0, 0, 11'd0,  4'b0000, 32'h0,        0, 0});
    tbl.push_back('{1'b0, 8'h0A, 0, 0, 11'd0,  4'b0000, 32'h0,        1, 0});
    tbl.push_back('{1'b0, 8'hC1, 1, 1, 11'd20, 4'b0001, 32'hC1C1C1C1, 1, 1});
    tbl.push_back('{1'b0, 8'h0A, 0, 0, 11'd0,  4'b0000, 32'h0,        2, 1});
    tbl.push_back('{1'b0, 8'h0A, 0, 0, 11'd0,  4'b0000, 32'h0,        3, 1});
    tbl.push_back('{1'b0, 8'h61, 1, 1, 11'd60, 4'b0010, 32'h61616161, 3, 2});
    tbl.push_back('{1'b0, 8'h62, 1, 1, 11'd60, 4'b0100, 32'h62626262, 3, 3});
    tbl.push_back('{1'b0, 8'h63, 1, 1, 11'd60, 4'b1000, 32'h63636363, 3, 4});
    tbl.push_back('{1'b0, 8'h64, 1, 1, 11'd61, 4'b0001, 32'h64646464, 3, 5});
    tbl.push_back('{1'b0, 8'h08, 1, 1, 11'd61, 4'b0001, 32'h20202020, 3, 4});
    tbl.push_back('{1'b0, 8'h0D, 0, 0, 11'd0,  4'b0000, 32'h0,        3, 0});
    tbl.push_back('{1'b0, 8'h08, 0, 0, 11'd0,  4'b0000, 32'h0,        3, 0});

    // Reset state
    repeat (2) @(negedge Clk);
    chk("rst_we", vram_we, 0);
    chk("rst_be", vram_be, 0);
    chk("rst_addr", vram_addr, 0);
    chk("rst_wdata", vram_wdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", char_ready, 1);
    chk("rst_cursor", {cursor_row, cursor_col}, 12'd0);
    Reset = 1'b0;

    // Table-driven single-byte behaviour
    foreach (tbl[i]) begin
      if (tbl[i].rst) do_reset();
      send(tbl[i].ch);
      chk($sformatf("v%0d_busy", i), cyc_q.size(), tbl[i].busy);
      chk($sformatf("v%0d_nwr", i), n_writes(), tbl[i].nwr);
      chk($sformatf("v%0d_row", i), cursor_row, tbl[i].row);
      chk($sformatf("v%0d_col", i), cursor_col, tbl[i].col);
      if (tbl[i].nwr == 1 && cyc_q.size() > 0) begin
        chk($sformatf("v%0d_addr", i), cyc_q[0].addr, tbl[i].addr);
        chk($sformatf("v%0d_be", i), cyc_q[0].be, tbl[i].be);
        chk($sformatf("v%0d_wdata", i), cyc_q[0].wdata, tbl[i].wd);
      end
    end

    // Form feed: clears all 600 words
    send(8'h0C);
    chk("ff_busy", cyc_q.size(), 600);
    errs = 0;
    foreach (cyc_q[i])
      if (!(cyc_q[i].we && cyc_q[i].addr == 11'(i) && cyc_q[i].be == 4'hF &&
            cyc_q[i].wdata == 32'h20202020)) errs++;
    chk("ff_writes", errs, 0);
    chk("ff_cursor", {cursor_row, cursor_col}, 12'd0);
    cmp_screen("ff_screen");

    // 80 printable bytes fill row 0 and wrap without scrolling
    do_reset();
    for (int i = 0; i < 80; i++) send(8'h41 + 8'(i % 26));
    chk("row_last_busy", cyc_q.size(), 1);
    if (cyc_q.size() > 0) begin
      chk("row_last_addr", cyc_q[0].addr, 19);
      chk("row_last_be", cyc_q[0].be, 4'b1000);
    end
    chk("row_wrap_cursor", {cursor_row, cursor_col}, {5'd1, 7'd0});
    cmp_screen("row_screen");

    // Walk to (29,79) leaving marks on every row, then wrap into a scroll
    for (int i = 0; i < 28; i++) begin
      send(8'h30 + 8'(i));
      send(8'h0D);
      send(8'h0A);
    end
    for (int i = 0; i < 79; i++) send(8'h61 + 8'(i % 26));
    chk("pre_scroll_cursor", {cursor_row, cursor_col}, {5'd29, 7'd79});
    snap = scr;
    snap[29][79] = 8'h5A;
    send(8'h5A);
    chk("scroll_busy", cyc_q.size(), 1181);
    if (cyc_q.size() == 1181) begin
      chk("scroll_first_wr", {cyc_q[0].we, cyc_q[0].addr, cyc_q[0].be, cyc_q[0].wdata},
          {1'b1, 11'd599, 4'b1000, 32'h5A5A5A5A});
      errs = 0;
      for (int i = 0; i < 580; i++) begin
        if (cyc_q[1+2*i].we !== 1'b0 || cyc_q[1+2*i].addr !== 11'(i + 20)) errs++;
        if (cyc_q[2+2*i].we !== 1'b1 || cyc_q[2+2*i].addr !== 11'(i) ||
            cyc_q[2+2*i].be !== 4'hF || cyc_q[2+2*i].wdata !== snap_word(i + 20)) errs++;
      end
      chk("scroll_pairs", errs, 0);
      errs = 0;
      for (int j = 0; j < 20; j++)
        if (!(cyc_q[1161+j].we && cyc_q[1161+j].addr == 11'(580 + j) &&
              cyc_q[1161+j].be == 4'hF && cyc_q[1161+j].wdata == 32'h20202020)) errs++;
      chk("scroll_blank_row", errs, 0);
    end
    chk("scroll_cursor", {cursor_row, cursor_col}, {5'd29, 7'd0});
    cmp_screen("scroll_screen");

    // Form feed interrupted by reset at its 301st write
    send(8'h0C);
    send(8'h51);
    for (int i = 0; i < 16; i++) send(8'h0A);
    send(8'h52);
    @(negedge Clk);
    char_valid = 1'b1;
    char_data  = 8'h0C;
    @(posedge Clk);
    #1;
    char_valid = 1'b0;
    got = 0;
    for (int n = 0; n < 700; n++) begin
      @(negedge Clk);
      if (vram_we && vram_addr == 11'd300) begin got = 1; break; end
    end
    chk("ff_reach_300", got, 1);
    #1 Reset = 1'b1;
    #1;
    chk("abort_outputs", {vram_we, vram_be, vram_addr, vram_wdata, busy, char_ready},
        {1'b0, 4'h0, 11'd0, 32'h0, 1'b0, 1'b1});
    chk("abort_cursor", {cursor_row, cursor_col}, 12'd0);
    @(negedge Clk);
    Reset = 1'b0;
    mr = 0; mc = 0;
    for (int r = 0; r < 30; r++)
      for (int c = 0; c < 80; c++)
        if (r*20 + c/4 < 300) scr[r][c] = 8'h20;
    cmp_screen("abort_screen");

    // Random byte stream against the model
    for (int i = 0; i < 500; i++) begin
      rsel = $urandom_range(0, 99);
      if (rsel < 70)      b = 8'($urandom_range(32, 255));
      else if (rsel < 80) b = 8'h0A;
      else if (rsel < 87) b = 8'h0D;
      else if (rsel < 98) b = 8'h08;
      else                b = 8'h0C;
      send(b);
      k = cyc_q.size();
      chk($sformatf("rnd%0d_busy(b=%02h)", i, b), k, exp_busy);
      chk($sformatf("rnd%0d_row", i), cursor_row, mr);
      chk($sformatf("rnd%0d_col", i), cursor_col, mc);
      if (i % 50 == 49) cmp_screen($sformatf("rnd%0d_screen", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
